// File: rtl/sram_resp_mem_pkg.sv
// Shared constants and helpers for the dual-port SRAM response memory:
// MIPS segment codes, the kseg fold mask and the default word-index width.
package sram_resp_mem_pkg;

    localparam int          ADDR_W_DEFAULT = 16;
    localparam logic [31:0] KSEG_MASK      = 32'h1FFF_FFFF;
    localparam logic [2:0]  SEG_KSEG0      = 3'b100;
    localparam logic [2:0]  SEG_KSEG1      = 3'b101;

    // kseg0 and kseg1 both alias the bottom 512 MiB of physical space.
    function automatic logic [31:0] kseg_fold(input logic [31:0] vaddr);
        if ((vaddr[31:29] == SEG_KSEG0) || (vaddr[31:29] == SEG_KSEG1))
            return vaddr & KSEG_MASK;
        else
            return vaddr;
    endfunction

endpackage

// File: rtl/sram_addr_map.sv
// Combinational virtual-to-word-index map for one SRAM port, including the
// range check against the configured memory capacity.
module sram_addr_map
    import sram_resp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [31:0]       vaddr,
    output logic [ADDR_W-1:0] idx,
    output logic              in_range
);

    logic [31:0] paddr;
    logic        unused_byte_offset;

    assign paddr    = kseg_fold(vaddr);
    assign idx      = paddr[ADDR_W+1:2];
    assign in_range = (paddr[31:ADDR_W+2] == '0);

    // Byte offset never selects a word; lanes are chosen by the write enables.
    assign unused_byte_offset = ^paddr[1:0];

endmodule

// File: rtl/sram_resp_mem.sv
// Dual-port 32-bit memory serving the core's instruction and data SRAM ports
// with one-cycle reads, byte-lane writes, write-first bypass and fault capture.
module sram_resp_mem
    import sram_resp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_valid,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              inst_in_range;
    logic              data_in_range;

    logic              data_wr_ok;
    logic              data_fault;
    logic              inst_fault;
    logic              bypass_hit;
    logic [31:0]       inst_word;
    logic [31:0]       data_word;
    logic              unused_inst_wdata;

    logic [31:0]       inst_rdata_reg, inst_rdata_next;
    logic [31:0]       data_rdata_reg, data_rdata_next;
    logic              err_valid_reg,  err_valid_next;
    logic [31:0]       err_addr_reg,   err_addr_next;

    sram_addr_map #(.ADDR_W(ADDR_W)) u_inst_map (
        .vaddr    (inst_sram_addr),
        .idx      (inst_idx),
        .in_range (inst_in_range)
    );

    sram_addr_map #(.ADDR_W(ADDR_W)) u_data_map (
        .vaddr    (data_sram_addr),
        .idx      (data_idx),
        .in_range (data_in_range)
    );

    // The instruction port can never write; its wdata is deliberately dropped.
    assign unused_inst_wdata = ^inst_sram_wdata;

    assign data_wr_ok = data_sram_en && (data_sram_wen != 4'h0) && data_in_range;
    assign data_fault = data_sram_en && !data_in_range;
    assign inst_fault = inst_sram_en && (!inst_in_range || (inst_sram_wen != 4'h0));
    assign bypass_hit = data_wr_ok && inst_sram_en && inst_in_range && (inst_idx == data_idx);

    // One byte-wide array per lane so each write enable maps to its own RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (rst && data_wr_ok && data_sram_wen[gi])
                    mem_lane[data_idx] <= data_sram_wdata[8*gi +: 8];
            end

            assign data_word[8*gi +: 8] = mem_lane[data_idx];
            assign inst_word[8*gi +: 8] = (bypass_hit && data_sram_wen[gi])
                                          ? data_sram_wdata[8*gi +: 8]
                                          : mem_lane[inst_idx];
        end
    endgenerate

    always_comb begin
        inst_rdata_next = inst_rdata_reg;
        data_rdata_next = data_rdata_reg;
        err_valid_next  = err_valid_reg;
        err_addr_next   = err_addr_reg;

        if (inst_sram_en)
            inst_rdata_next = inst_in_range ? inst_word : 32'h0;

        if (data_sram_en && (data_sram_wen == 4'h0))
            data_rdata_next = data_in_range ? data_word : 32'h0;

        // Only the first fault is recorded; the data port wins a tie.
        if (!err_valid_reg && (data_fault || inst_fault)) begin
            err_valid_next = 1'b1;
            err_addr_next  = data_fault ? data_sram_addr : inst_sram_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata_reg <= 32'h0;
            data_rdata_reg <= 32'h0;
            err_valid_reg  <= 1'b0;
            err_addr_reg   <= 32'h0;
        end else begin
            inst_rdata_reg <= inst_rdata_next;
            data_rdata_reg <= data_rdata_next;
            err_valid_reg  <= err_valid_next;
            err_addr_reg   <= err_addr_next;
        end
    end

    assign inst_sram_rdata = inst_rdata_reg;
    assign data_sram_rdata = data_rdata_reg;
    assign err_valid       = err_valid_reg;
    assign err_addr        = err_addr_reg;

endmodule

// File: tb/tb_sram_resp_mem.sv
// Directed self-checking bench for sram_resp_mem: reset, lane merge, kseg
// aliasing, collision bypass, idle hold, fault capture and reset mid-write.
module tb_sram_resp_mem;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        err_valid;
    logic [31:0] err_addr;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    sram_resp_mem #(.ADDR_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .err_valid       (err_valid),
        .err_addr        (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic data_wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic data_rd(input logic [31:0] addr);
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'h0;
        data_sram_addr  = addr;
        data_sram_wdata = 32'h0;
    endtask

    task automatic data_idle();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
    endtask

    task automatic inst_rd(input logic [31:0] addr);
        inst_sram_en    = 1'b1;
        inst_sram_wen   = 4'h0;
        inst_sram_addr  = addr;
        inst_sram_wdata = 32'h0;
    endtask

    task automatic inst_idle();
        inst_sram_en  = 1'b0;
        inst_sram_wen = 4'h0;
    endtask

    initial begin
        rst = 1'b0;
        inst_sram_addr = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0;
        inst_idle();
        data_idle();

        repeat (3) step();
        chk("reset_inst_rdata", inst_sram_rdata, 32'h0);
        chk("reset_data_rdata", data_sram_rdata, 32'h0);
        chk("reset_err_valid",  {31'h0, err_valid}, 32'h0);
        chk("reset_err_addr",   err_addr, 32'h0);
        rst = 1'b1;

        data_wr(32'h8000_0000, 4'hF, 32'h1111_1111); step();
        data_wr(32'h8000_0010, 4'hF, 32'hAABB_CCDD); step();
        data_wr(32'h8000_0010, 4'b0010, 32'h0000_1100); step();
        chk("data_hold_on_write", data_sram_rdata, 32'h0);

        data_rd(32'hA000_0010); inst_rd(32'hA000_0010); step();
        chk("lane_merge_data_kseg1", data_sram_rdata, 32'hAABB_11DD);
        chk("lane_merge_inst_kseg1", inst_sram_rdata, 32'hAABB_11DD);

        data_wr(32'h8000_0100, 4'hF, 32'h1234_5678); inst_rd(32'h8000_0100); step();
        chk("bypass_full_word", inst_sram_rdata, 32'h1234_5678);
        chk("data_hold_during_bypass", data_sram_rdata, 32'hAABB_11DD);

        data_wr(32'h8000_0100, 4'b0001, 32'h0000_00EF); inst_rd(32'h8000_0100); step();
        chk("bypass_one_lane", inst_sram_rdata, 32'h1234_56EF);

        data_rd(32'h8000_0100); inst_idle(); step();
        chk("data_read_after_write", data_sram_rdata, 32'h1234_56EF);

        data_rd(32'h8000_0010); step();
        data_idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle_hold_data_%0d", i), data_sram_rdata, 32'hAABB_11DD);
            chk($sformatf("idle_hold_inst_%0d", i), inst_sram_rdata, 32'h1234_56EF);
        end
        chk("no_fault_yet", {31'h0, err_valid}, 32'h0);

        data_rd(32'h0004_0000); step();
        chk("oor_read_zero", data_sram_rdata, 32'h0);
        chk("oor_err_valid", {31'h0, err_valid}, 32'h1);
        chk("oor_err_addr",  err_addr, 32'h0004_0000);

        data_idle();
        inst_sram_en = 1'b1; inst_sram_wen = 4'hF;
        inst_sram_addr = 32'h8000_0000; inst_sram_wdata = 32'hDEAD_BEEF;
        step();
        chk("inst_write_as_read", inst_sram_rdata, 32'h1111_1111);
        chk("err_addr_sticky", err_addr, 32'h0004_0000);

        inst_idle(); data_rd(32'h8000_0000); step();
        chk("inst_write_suppressed", data_sram_rdata, 32'h1111_1111);

        data_wr(32'h8000_0020, 4'hF, 32'h5555_5555); step();
        data_wr(32'h8000_0020, 4'hF, 32'h9999_9999);
        rst = 1'b0;
        #1;
        chk("async_reset_data_rdata", data_sram_rdata, 32'h0);
        chk("async_reset_inst_rdata", inst_sram_rdata, 32'h0);
        chk("async_reset_err_valid",  {31'h0, err_valid}, 32'h0);
        chk("async_reset_err_addr",   err_addr, 32'h0);
        step(); step();
        rst = 1'b1;
        data_rd(32'h8000_0020); step();
        chk("reset_drops_write", data_sram_rdata, 32'h5555_5555);

        data_rd(32'hFFFF_0000); inst_rd(32'h0008_0000); step();
        chk("dual_fault_err_valid", {31'h0, err_valid}, 32'h1);
        chk("dual_fault_data_wins", err_addr, 32'hFFFF_0000);
        chk("dual_fault_inst_zero", inst_sram_rdata, 32'h0);

        data_rd(32'h1000_0000); inst_idle(); step();
        chk("later_fault_ignored", err_addr, 32'hFFFF_0000);
        chk("oor_low_seg_zero", data_sram_rdata, 32'h0);

        data_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/sram_resp_mem.md
# sram_resp_mem

Synchronous dual-port memory that answers the core's instruction and data SRAM-style ports (`*_sram_en/wen/addr/wdata/rdata`). It sits directly below the CPU core in simulation and FPGA builds and provides storage for both fetch and load/store. Each port is served with a fixed one-cycle read latency and byte-lane writes. The block also applies MIPS kseg0/kseg1 address folding and flags out-of-range or illegal accesses.

## Interface
Parameters:
- `ADDR_W`, default 16: word-index width; capacity is 2^ADDR_W 32-bit words (256 KiB at default).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `inst_sram_en`  in  1  instruction-port access enable.
- `inst_sram_wen`  in  4  instruction-port byte write enables; must be 0.
- `inst_sram_addr`  in  32  instruction-port virtual byte address.
- `inst_sram_wdata`  in  32  instruction-port write data; ignored.
- `inst_sram_rdata`  out  32  instruction-port read data, registered.
- `data_sram_en`  in  1  data-port access enable.
- `data_sram_wen`  in  4  data-port byte write enables; bit i covers bits [8i+7:8i].
- `data_sram_addr`  in  32  data-port virtual byte address.
- `data_sram_wdata`  in  32  data-port write data, already lane-aligned by the core.
- `data_sram_rdata`  out  32  data-port read data, registered.
- `err_valid`  out  1  sticky: at least one faulting access has occurred since reset.
- `err_addr`  out  32  virtual address of the first faulting access.

## Operation
Address folding, applied to each port independently:
- `addr[31:29]` = 3'b100 (kseg0) or 3'b101 (kseg1): paddr = `addr & 32'h1FFF_FFFF`.
- Otherwise: paddr = addr.
- Word index = `paddr[ADDR_W+1:2]`. `addr[1:0]` is ignored for indexing.
- The access is in range iff `paddr[31:ADDR_W+2]` == 0.

Access types, per port, each cycle:
- Read (en=1, wen=0, in range): `rdata` <= mem[idx].
- Write (data port only; en=1, wen≠0, in range): mem[idx] byte lanes with wen[i]=1 <= wdata lanes. `data_sram_rdata` holds its previous value.
- Idle (en=0): `rdata` holds its previous value.
- Out-of-range read: `rdata` <= 32'h0; counts as a fault.
- Out-of-range write: no array update; counts as a fault.
- Instruction port with en=1 and wen≠0: write suppressed, treated as a read, counts as a fault.

Collision rules:
- The data port writes word W while the instruction port reads W in the same cycle: `inst_sram_rdata` returns the merged new word (write-first bypass).
- The data port never sees its own write reflected in the same cycle.

Fault capture:
- On the first fault after reset, `err_valid` <= 1 and `err_addr` <= the faulting virtual address.
- If both ports fault in the same cycle, the data-port address is captured.
- Later faults do not change `err_addr`.

Reset:
- Asserting `rst` forces `inst_sram_rdata`, `data_sram_rdata`, `err_valid` and `err_addr` to 0 immediately.
- Array contents are not cleared.
- Any access sampled while `rst` is low is dropped. No partial write occurs.

## Timing
- Read latency: exactly 1 cycle, en sampled at edge N gives data valid after edge N. No back-pressure and no ready signal; a new access is accepted every cycle on each port.
- Write: the array is updated at the sampling edge. A read of the same word by the data port at edge N+1 returns the new value.
- `err_valid`/`err_addr` update at the edge sampling the faulting access.
- Deassertion of `rst` is synchronised by the system; the first access is sampled at the first edge with `rst` high.

## Structure
- Shared package holds:
  - `KSEG_MASK` = 32'h1FFF_FFFF;
  - segment codes `SEG_KSEG0` = 3'b100 and `SEG_KSEG1` = 3'b101;
  - the `ADDR_W` default.
- Sub-module `sram_addr_map` (combinational), instantiated once per port: virtual addr in → word index and `in_range` out.
- The top level contains:
  - the 2^ADDR_W × 32 array;
  - the per-lane write merge;
  - the bypass compare;
  - both rdata registers;
  - the fault-capture registers.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → both rdata = 0, `err_valid` = 0, `err_addr` = 0. Then release.
- **Byte-lane merge:** data write 32'hAABB_CCDD to 32'h8000_0010 with wen=4'hF, then wen=4'b0010 with wdata 32'h0000_1100. Then read 32'hA000_0010 → 32'hAABB_11DD one cycle later (kseg0/kseg1 alias the same word).
- **Collision bypass:** in the same cycle, data-write 32'h1234_5678 to 32'h8000_0100 and inst-read 32'h8000_0100 → `inst_sram_rdata` = 32'h1234_5678 next cycle.
- **Hold on idle:** read 32'h8000_0010, then set en=0 for 4 cycles → rdata holds 32'hAABB_11DD throughout.
- **Out-of-range fault:** with ADDR_W=16, data-read 32'h0004_0000 → rdata = 0, `err_valid` = 1, `err_addr` = 32'h0004_0000. A later inst write attempt to 32'h8000_0000 with wen=4'hF leaves the array and `err_addr` unchanged.
- **Reset mid-write:** drop `rst` in the same cycle as a data write to 32'h8000_0020 → a later read returns the pre-write contents.
